// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : adder_32bit / mult_seq_ctrl
// Brief    : 32x32->64 unsigned shift-add multiplier, one partial add per clk.
// Revision : 1.0
// ============================================================================

module adder_32bit (
   input  logic [31:0] i0,
   input  logic [31:0] i1,
   input  logic        carry_in,
   output logic [31:0] sum,
   output logic        carry_out
);
   assign {carry_out, sum} = {1'b0, i0} + {1'b0, i1} + {32'h0, carry_in};
endmodule

module mult_seq_ctrl #(
   parameter int DONE_HOLD = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] multiplicand,
   input  logic [31:0] multiplier,
   output logic        busy,
   output logic        done,
   output logic [63:0] product,
   output logic [5:0]  iter_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] a_q, a_d;
   logic [63:0] p_q, p_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [63:0] product_q, product_d;

   logic [31:0] w_add_i1;
   logic [31:0] w_add_sum;
   logic        w_add_co;

   assign w_add_i1 = p_q[0] ? a_q : 32'h0;

   adder_32bit u_adder (
      .i0        (p_q[63:32]),
      .i1        (w_add_i1),
      .carry_in  (1'b0),
      .sum       (w_add_sum),
      .carry_out (w_add_co)
   );

   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      p_d       = p_q;
      cnt_d     = cnt_q;
      product_d = product_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_d     = multiplicand;
               p_d     = {32'h0, multiplier};
               cnt_d   = 6'd0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            p_d   = {w_add_co, w_add_sum, p_q[31:1]};
            cnt_d = cnt_q + 6'd1;
            // 32nd add lands on this edge, so DONE is entered together with it
            if (cnt_q == 6'd31) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               a_d     = multiplicand;
               p_d     = {32'h0, multiplier};
               cnt_d   = 6'd0;
               state_d = ST_RUN;
            end else if (DONE_HOLD == 0) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Intermediate partial products never reach the output
      if (state_d != ST_RUN) begin
         product_d = p_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_q       <= 32'h0;
         p_q       <= 64'h0;
         cnt_q     <= 6'd0;
         product_q <= 64'h0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         p_q       <= p_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end

   assign busy     = (state_q == ST_RUN);
   assign done     = (state_q == ST_DONE);
   assign product  = product_q;
   assign iter_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_seq_ctrl
// Brief    : Timeline/product checks for both DONE_HOLD variants side by side.
// Revision : 1.0
// ============================================================================

module tb_mult_seq_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [31:0] multiplicand;
   logic [31:0] multiplier;

   logic        busy0, done0, busy1, done1;
   logic [63:0] product0, product1;
   logic [5:0]  iter0, iter1;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [63:0] exp_prod;

   always #5 clk = ~clk;

   mult_seq_ctrl #(.DONE_HOLD(0)) dut0 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy0),
      .done         (done0),
      .product      (product0),
      .iter_cnt     (iter0)
   );

   mult_seq_ctrl #(.DONE_HOLD(1)) dut1 (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .busy         (busy1),
      .done         (done1),
      .product      (product1),
      .iter_cnt     (iter1)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input logic b, input logic d0,
                            input logic d1, input int it, input logic [63:0] prod);
      chk({tag, ".busy0"},    64'(busy0),    64'(b));
      chk({tag, ".busy1"},    64'(busy1),    64'(b));
      chk({tag, ".done0"},    64'(done0),    64'(d0));
      chk({tag, ".done1"},    64'(done1),    64'(d1));
      chk({tag, ".iter0"},    64'(iter0),    64'(it));
      chk({tag, ".iter1"},    64'(iter1),    64'(it));
      chk({tag, ".product0"}, product0,      prod);
      chk({tag, ".product1"}, product1,      prod);
   endtask

   // Called at a negedge: start is accepted at the next posedge. Returns at
   // the negedge of the done cycle. inject >= 0 pulses a stray start in RUN.
   task automatic op(input logic [31:0] a, input logic [31:0] b, input int inject);
      logic [63:0] prev;
      prev         = exp_prod;
      start        = 1'b1;
      multiplicand = a;
      multiplier   = b;
      @(negedge clk);
      start = 1'b0;
      for (int j = 0; j < 32; j++) begin
         if (j > 0) @(negedge clk);
         if (j == inject) begin
            start        = 1'b1;
            multiplicand = 32'd1;
            multiplier   = 32'd1;
         end else if (j == inject + 1) begin
            start = 1'b0;
         end
         chk_state($sformatf("run%0d", j), 1'b1, 1'b0, 1'b0, j, prev);
      end
      @(negedge clk);
      start    = 1'b0;
      exp_prod = 64'(a) * 64'(b);
      chk_state("done", 1'b0, 1'b1, 1'b1, 32, exp_prod);
   endtask

   task automatic idle_steps(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         chk_state("idle", 1'b0, 1'b0, 1'b1, 32, exp_prod);
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      start        = 1'b0;
      multiplicand = 32'hDEAD_BEEF;
      multiplier   = 32'h1234_5678;
      exp_prod     = 64'h0;
      repeat (3) @(negedge clk);
      chk_state("reset", 1'b0, 1'b0, 1'b0, 0, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);
      chk_state("post_reset", 1'b0, 1'b0, 1'b0, 0, 64'h0);

      op(32'd3, 32'd5, -1);
      chk("basic_val", exp_prod, 64'h0000_0000_0000_000F);
      idle_steps(2);

      op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      chk("max_val", product0, 64'hFFFF_FFFE_0000_0001);
      idle_steps(1);
      op(32'h8000_0000, 32'd2, -1);
      chk("carry_val", product0, 64'h0000_0001_0000_0000);
      idle_steps(1);

      op(32'd7, 32'd9, 10);
      chk("ignored_start_val", product0, 64'd63);
      idle_steps(3);

      // Reset in the middle of RUN abandons the operation
      start        = 1'b1;
      multiplicand = $urandom;
      multiplier   = $urandom;
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      chk_state("pre_abort", 1'b1, 1'b0, 1'b0, 14, exp_prod);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n    = 1'b1;
      exp_prod = 64'h0;
      chk_state("abort", 1'b0, 1'b0, 1'b0, 0, 64'h0);
      @(negedge clk);
      chk_state("abort_idle", 1'b0, 1'b0, 1'b0, 0, 64'h0);

      op(32'd2, 32'd3, -1);
      op(32'd10, 32'd10, -1);
      chk("b2b_val", product0, 64'd100);
      idle_steps(1);

      op(32'd4, 32'd4, -1);
      idle_steps(20);
      chk("hold_val", product1, 64'd16);
      op(32'd123, 32'd0, -1);
      chk("zero_mult", product0, 64'd0);
      idle_steps(1);

      for (int r = 0; r < 5; r++) begin
         op($urandom, $urandom, (r == 2) ? 20 : -1);
         if (r[0]) idle_steps(2);
      end
      op(32'hFFFF_FFFF, $urandom, -1);
      idle_steps(1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
